// File: rtl/hbridge_pwm_driver.sv
// Dual-channel H-bridge driver: shared PWM timebase, per-motor soft-start ramp,
// coast interval on reversal, and a sticky fault for contradictory commands.

module hbridge_pwm_channel #(
  parameter int PWM_BITS     = 8,
  parameter int RAMP_STEP    = 16,
  parameter int DEAD_PERIODS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                fwd,
  input  logic                bck,
  input  logic [PWM_BITS-1:0] duty_cmd,
  input  logic                boundary,
  input  logic [PWM_BITS-1:0] cnt_nxt,
  output logic                pwm,
  output logic                in1,
  output logic                in2
);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam int DEAD_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS + 1) : 1;

  logic [1:0]          state_q, state_d;
  logic                dir_fwd_q, dir_fwd_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic                pwm_q, pwm_d;

  logic                req_fwd, req_rev, req_run;
  logic [PWM_BITS:0]   ramp_sum;
  logic [PWM_BITS-1:0] ramp_sat;

  assign req_fwd = enable & fwd & ~bck;
  assign req_rev = enable & bck & ~fwd;
  assign req_run = req_fwd | req_rev;

  // One extra bit so the ramp saturates instead of wrapping past all-ones.
  assign ramp_sum = {1'b0, duty_q} + (PWM_BITS + 1)'(RAMP_STEP);
  assign ramp_sat = ramp_sum[PWM_BITS] ? '1 : ramp_sum[PWM_BITS-1:0];

  always_comb begin
    state_d   = state_q;
    dir_fwd_d = dir_fwd_q;
    duty_d    = duty_q;
    dead_d    = dead_q;
    case (state_q)
      ST_STOP: begin
        duty_d = '0;
        if (req_run) begin
          state_d   = ST_RUN;
          dir_fwd_d = req_fwd;
        end
      end
      ST_RUN: begin
        if (!req_run) begin
          state_d = ST_STOP;
          duty_d  = '0;
        end else if (req_fwd != dir_fwd_q) begin
          // Reversal wins over a coincident ramp update.
          state_d = ST_DEAD;
          dead_d  = DEAD_W'(DEAD_PERIODS);
          duty_d  = '0;
        end else if (boundary) begin
          if (duty_q < duty_cmd)
            duty_d = (ramp_sat < duty_cmd) ? ramp_sat : duty_cmd;
          else if (duty_q > duty_cmd)
            duty_d = duty_cmd;
        end
      end
      ST_DEAD: begin
        duty_d = '0;
        if (!req_run) begin
          state_d = ST_STOP;
        end else if (boundary) begin
          if (dead_q <= DEAD_W'(1)) begin
            state_d   = ST_RUN;
            dir_fwd_d = req_fwd;
            dead_d    = '0;
          end else begin
            dead_d = dead_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_STOP;
        duty_d  = '0;
      end
    endcase
  end

  // PWM is registered from next-state values so it stays aligned with state and cnt.
  assign pwm_d = (state_d == ST_RUN) && (cnt_nxt < duty_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_STOP;
      dir_fwd_q <= 1'b0;
      duty_q    <= '0;
      dead_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_fwd_q <= dir_fwd_d;
      duty_q    <= duty_d;
      dead_q    <= dead_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm = pwm_q;
  assign in1 = (state_q == ST_RUN) &&  dir_fwd_q;
  assign in2 = (state_q == ST_RUN) && !dir_fwd_q;

endmodule

module hbridge_pwm_driver #(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 4,
  parameter int RAMP_STEP    = 16,
  parameter int DEAD_PERIODS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                fwd_a,
  input  logic                bck_a,
  input  logic                fwd_b,
  input  logic                bck_b,
  input  logic [PWM_BITS-1:0] duty_cmd,
  output logic                pwm_a,
  output logic                in1_a,
  output logic                in2_a,
  output logic                pwm_b,
  output logic                in1_b,
  output logic                in2_b,
  output logic                fault
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]    pre_q;
  logic [PWM_BITS-1:0] cnt_q, cnt_nxt;
  logic                pre_wrap, boundary;

  assign pre_wrap = (pre_q == PRE_W'(PRESCALE - 1));
  assign cnt_nxt  = pre_wrap ? cnt_q + 1'b1 : cnt_q;
  assign boundary = pre_wrap && (cnt_q == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_wrap ? '0 : pre_q + 1'b1;
      cnt_q <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      fault <= 1'b0;
    else if ((fwd_a & bck_a) | (fwd_b & bck_b))
      fault <= 1'b1;
  end

  hbridge_pwm_channel #(
    .PWM_BITS    (PWM_BITS),
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_chan_a (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .fwd     (fwd_a),
    .bck     (bck_a),
    .duty_cmd(duty_cmd),
    .boundary(boundary),
    .cnt_nxt (cnt_nxt),
    .pwm     (pwm_a),
    .in1     (in1_a),
    .in2     (in2_a)
  );

  hbridge_pwm_channel #(
    .PWM_BITS    (PWM_BITS),
    .RAMP_STEP   (RAMP_STEP),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_chan_b (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .fwd     (fwd_b),
    .bck     (bck_b),
    .duty_cmd(duty_cmd),
    .boundary(boundary),
    .cnt_nxt (cnt_nxt),
    .pwm     (pwm_b),
    .in1     (in1_b),
    .in2     (in2_b)
  );

endmodule
